rob_alloc_ctrl: RTL and testbench
=================================

// Module: rob_alloc_ctrl
// PURPOSE
//  Sequences the reorder buffer: hands out in-order ROB pointers (pdst) to rename, records completion from
//  writeback, and presents up to COMMIT_W oldest contiguous complete entries to retire each cycle.
//  Sits between rename (allocation), execute writeback (completion) and commit (retire); owns head/tail.
// PARAMETERS
//  ROB_DEPTH    64  entries; power of two; PTR_W = $clog2(ROB_DEPTH)
//  ALLOC_W      2   allocation slots per cycle (FETCH_WIDTH)
//  COMMIT_W     2   retire slots per cycle (COMMIT_WIDTH)
//  CPL_W        4   writeback completion ports
//  RECOVER_CYC  2   cycles alloc is blocked after flush (RAT restore window); >=1
// PORTS
//  clk          in   1             clock
//  reset        in   1             synchronous, active-high
//  alloc_valid  in   ALLOC_W       request mask; must be contiguous from bit 0
//  alloc_ready  out  1             all requested slots granted this cycle (all-or-nothing)
//  alloc_ptr    out  ALLOC_W*PTR_W slot i pointer = tail+i
//  cpl_valid    in   CPL_W         completion strobes
//  cpl_ptr      in   CPL_W*PTR_W   completed entry pointers
//  commit_valid out  COMMIT_W      contiguous-from-bit-0 mask of retirable entries
//  commit_ptr   out  COMMIT_W*PTR_W slot i pointer = head+i
//  commit_ready in   1             retire accepts every slot flagged in commit_valid
//  flush        in   1             discard all in-flight entries
//  count        out  PTR_W+1       occupied entries
//  full, empty  out  1             count==ROB_DEPTH / count==0
// BEHAVIOUR
//  - Reset: head=tail=0 (PTR_W+1 bits incl. wrap), complete[]=0, state=RUN, count=0, empty=1, full=0,
//    alloc_ready=1, commit_valid=0.
//  - count = tail-head modulo 2^(PTR_W+1); all pointer arithmetic wraps silently.
//  - FSM: RUN -> RECOVER on flush (from any state, including RECOVER, which restarts the timer).
//    RECOVER -> RUN after RECOVER_CYC cycles (down-counter).
//  - alloc_ready = (state==RUN) && !flush && (ROB_DEPTH-count >= popcount(alloc_valid)).
//    It is combinational and depends only on registered state plus the current alloc_valid and flush.
//  - Allocation: on alloc_valid!=0 && alloc_ready, tail += popcount and complete[] of the new slots is cleared.
//  - Completion: sets complete[cpl_ptr] next cycle. Duplicate ports on the same pointer are legal.
//    A pointer outside [head,tail) is ignored. An entry can complete in the cycle after allocation at the earliest.
//  - commit_valid[i] = complete[head+i] && (i<count) && all lower slots valid && state==RUN.
//    It is driven combinationally from registers only; completion is never forwarded in the same cycle.
//  - On commit_ready with commit_valid!=0, head += popcount(commit_valid).
//  - Same-cycle alloc+commit: space check uses pre-commit count, so freed slots are reusable next cycle.
//    At full, alloc is blocked even when commit fires.
//  - Flush has priority over alloc, completion and commit in that cycle: head=tail=0, complete[]=0.
//    commit_valid=0 and alloc_ready=0 throughout RECOVER.
//  - Reset mid-operation behaves exactly like reset from idle. Reset has priority over flush.
//  - Assertions: alloc_valid contiguous; commit_ready only with commit_valid!=0.
// CONFIGURATION
//  ROB_ALLOC_CTRL_PERF_EN defined:
//    - adds outputs perf_full_stall (32b), counting cycles with alloc_valid!=0 && !alloc_ready && state==RUN.
//    - adds perf_commit_cnt (32b), counting committed entries.
//    - both saturate at all-ones and clear on reset only.
//  Undefined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - rename_pkg: rob_wptr_t (wrap bit + rob_ptr_t) and rob_ctrl_state_e {RUN,RECOVER}.
//  - config_pkg: ROB_DEPTH and RECOVER_CYC defaults.
//  - Sub-module rob_commit_sel (combinational): takes complete[] rotated at head plus count,
//    produces the contiguous commit_valid mask and its popcount.
//  - Everything else is flat in rob_alloc_ctrl.
// TESTING
//  1. Reset, alloc_valid=2'b11 x32 cycles with no completion.
//     -> ptrs 0..63 in order; full=1 at count=64; 33rd request gets alloc_ready=0.
//  2. Alloc 4 entries; complete ptr 1 then ptr 0; commit_ready=1.
//     -> commit_valid=2'b11 the cycle after ptr 0 completes; head=2; count=2.
//  3. Complete ptr 2 but not ptr 3 with COMMIT_W=2.
//     -> commit_valid=2'b01 only; no commit past the gap.
//  4. count=63, alloc_valid=2'b11 while committing 2.
//     -> alloc_ready=0 that cycle; alloc_ready=1 next cycle.
//  5. Flush with 10 in flight, simultaneous cpl_valid and alloc_valid.
//     -> count=0; alloc_ready=0 for 2 cycles; next alloc_ptr=0; stale completion never commits.
//  6. Run 200 alloc/commit cycles across the wrap.
//     -> ptr 63 is followed by 0; count stays correct; scoreboard ordering is intact.

Source files
------------

// File: rtl/config_pkg.sv
// Build-time defaults for the reorder-buffer control slice.
package config_pkg;
  localparam int unsigned ROB_DEPTH   = 64;
  localparam int unsigned RECOVER_CYC = 2;
endpackage

// File: rtl/rename_pkg.sv
// Shared rename/ROB types: wrap-extended ROB pointer and ROB control FSM states.
package rename_pkg;
  localparam int unsigned ROB_PTR_W = $clog2(config_pkg::ROB_DEPTH);

  typedef logic [ROB_PTR_W-1:0] rob_ptr_t;

  typedef struct packed {
    logic     wrap;
    rob_ptr_t idx;
  } rob_wptr_t;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } rob_ctrl_state_e;
endpackage

// File: rtl/rob_commit_sel.sv
// Builds the contiguous-from-slot-0 retire mask from the complete[] window at head,
// and reports how many slots it covers.
module rob_commit_sel #(
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned CNT_W    = 7
) (
  input  logic                en_i,
  input  logic [COMMIT_W-1:0] win_i,
  input  logic [CNT_W-1:0]    count_i,
  output logic [COMMIT_W-1:0] valid_o,
  output logic [CNT_W-1:0]    num_o
);

  logic run;

  always_comb begin
    valid_o = '0;
    num_o   = '0;
    run     = en_i;
    for (int unsigned i = 0; i < COMMIT_W; i++) begin
      // a gap or an unoccupied slot stops retirement for every younger slot
      run        = run && win_i[i] && (count_i > CNT_W'(i));
      valid_o[i] = run;
      if (run) begin
        num_o = num_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rob_alloc_ctrl.sv
// ROB head/tail sequencer: in-order allocation, completion tracking and commit selection.
// Optional perf counters are built when ROB_ALLOC_CTRL_PERF_EN is defined.
module rob_alloc_ctrl
  import rename_pkg::*;
#(
  parameter int unsigned ROB_DEPTH   = config_pkg::ROB_DEPTH,
  parameter int unsigned ALLOC_W     = 2,
  parameter int unsigned COMMIT_W    = 2,
  parameter int unsigned CPL_W       = 4,
  parameter int unsigned RECOVER_CYC = config_pkg::RECOVER_CYC,
  localparam int unsigned PTR_W      = $clog2(ROB_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ALLOC_W-1:0]        alloc_valid,
  output logic                      alloc_ready,
  output logic [ALLOC_W*PTR_W-1:0]  alloc_ptr,
  input  logic [CPL_W-1:0]          cpl_valid,
  input  logic [CPL_W*PTR_W-1:0]    cpl_ptr,
  output logic [COMMIT_W-1:0]       commit_valid,
  output logic [COMMIT_W*PTR_W-1:0] commit_ptr,
  input  logic                      commit_ready,
  input  logic                      flush,
  output logic [PTR_W:0]            count,
  output logic                      full,
  output logic                      empty
`ifdef ROB_ALLOC_CTRL_PERF_EN
  ,
  output logic [31:0]               perf_full_stall,
  output logic [31:0]               perf_commit_cnt
`endif
);

  localparam int unsigned TMR_W = $clog2(RECOVER_CYC + 1);

  typedef logic [PTR_W:0] wptr_t;

  localparam wptr_t            DEPTH_W  = wptr_t'(ROB_DEPTH);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RECOVER_CYC - 1);

  rob_ctrl_state_e      state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  wptr_t                head_q, head_d;
  wptr_t                tail_q, tail_d;
  logic [ROB_DEPTH-1:0] cpl_q, cpl_d;

  wptr_t                alloc_n;
  wptr_t                commit_n;
  wptr_t                free_slots;
  logic [COMMIT_W-1:0]  win;
  logic                 alloc_fire;
  logic                 commit_fire;
  logic                 run;

  assign run        = (state_q == RUN);
  assign count      = tail_q - head_q;
  assign full       = (count == DEPTH_W);
  assign empty      = (count == '0);
  assign free_slots = DEPTH_W - count;

  always_comb begin
    alloc_n = '0;
    for (int unsigned i = 0; i < ALLOC_W; i++) begin
      alloc_n = alloc_n + wptr_t'(alloc_valid[i]);
    end
  end

  // space check uses pre-commit occupancy; slots freed this cycle are reusable next cycle
  assign alloc_ready = run && !flush && (free_slots >= alloc_n);
  assign alloc_fire  = alloc_ready && (alloc_valid != '0);
  assign commit_fire = commit_ready && (commit_valid != '0);

  always_comb begin
    alloc_ptr  = '0;
    commit_ptr = '0;
    win        = '0;
    for (int unsigned i = 0; i < ALLOC_W; i++) begin
      alloc_ptr[i*PTR_W +: PTR_W] = tail_q[PTR_W-1:0] + PTR_W'(i);
    end
    for (int unsigned i = 0; i < COMMIT_W; i++) begin
      commit_ptr[i*PTR_W +: PTR_W] = head_q[PTR_W-1:0] + PTR_W'(i);
      win[i]                       = cpl_q[head_q[PTR_W-1:0] + PTR_W'(i)];
    end
  end

  rob_commit_sel #(
    .COMMIT_W (COMMIT_W),
    .CNT_W    (PTR_W + 1)
  ) u_commit_sel (
    .en_i    (run),
    .win_i   (win),
    .count_i (count),
    .valid_o (commit_valid),
    .num_o   (commit_n)
  );

  always_comb begin
    logic [PTR_W-1:0] off;
    logic [PTR_W-1:0] idx;
    state_d = state_q;
    tmr_d   = tmr_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cpl_d   = cpl_q;
    off     = '0;
    idx     = '0;
    if (flush) begin
      state_d = RECOVER;
      tmr_d   = TMR_LOAD;
      head_d  = '0;
      tail_d  = '0;
      cpl_d   = '0;
    end else begin
      if (state_q == RECOVER) begin
        if (tmr_q == '0) begin
          state_d = RUN;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      // only entries in [head,tail) as of this cycle may be marked complete
      for (int unsigned p = 0; p < CPL_W; p++) begin
        idx = cpl_ptr[p*PTR_W +: PTR_W];
        off = idx - head_q[PTR_W-1:0];
        if (cpl_valid[p] && ({1'b0, off} < count)) begin
          cpl_d[idx] = 1'b1;
        end
      end
      if (commit_fire) begin
        head_d = head_q + commit_n;
      end
      if (alloc_fire) begin
        for (int unsigned i = 0; i < ALLOC_W; i++) begin
          idx = tail_q[PTR_W-1:0] + PTR_W'(i);
          if (alloc_valid[i]) begin
            cpl_d[idx] = 1'b0;
          end
        end
        tail_d = tail_q + alloc_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      tmr_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cpl_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cpl_q   <= cpl_d;
    end
  end

`ifdef ROB_ALLOC_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] ccnt_q;
  logic [32:0] ccnt_sum;

  assign ccnt_sum = {1'b0, ccnt_q} + 33'(commit_n);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      ccnt_q  <= '0;
    end else begin
      if ((alloc_valid != '0) && !alloc_ready && run && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (commit_fire && !flush) begin
        ccnt_q <= ccnt_sum[32] ? '1 : ccnt_sum[31:0];
      end
    end
  end

  assign perf_full_stall = stall_q;
  assign perf_commit_cnt = ccnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ((alloc_valid & (alloc_valid + 1'b1)) == '0);
      assert (!commit_ready || (commit_valid != '0));
    end
  end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Scoreboard bench for rob_alloc_ctrl against a queue-based ROB occupancy model.
module tb_rob_alloc_ctrl;
  localparam int DEPTH = 64;
  localparam int PW    = 6;
  localparam int RC    = 2;

  logic        clk          = 1'b0;
  logic        reset        = 1'b1;
  logic [1:0]  alloc_valid  = '0;
  logic        alloc_ready;
  logic [11:0] alloc_ptr;
  logic [3:0]  cpl_valid    = '0;
  logic [23:0] cpl_ptr      = '0;
  logic [1:0]  commit_valid;
  logic [11:0] commit_ptr;
  logic        commit_ready = 1'b0;
  logic        flush        = 1'b0;
  logic [6:0]  count;
  logic        full;
  logic        empty;

  always #5 clk = ~clk;

  rob_alloc_ctrl #(
    .ROB_DEPTH   (64),
    .ALLOC_W     (2),
    .COMMIT_W    (2),
    .CPL_W       (4),
    .RECOVER_CYC (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_ptr    (alloc_ptr),
    .cpl_valid    (cpl_valid),
    .cpl_ptr      (cpl_ptr),
    .commit_valid (commit_valid),
    .commit_ptr   (commit_ptr),
    .commit_ready (commit_ready),
    .flush        (flush),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  typedef struct {
    bit        ar;
    bit [11:0] ap;
    bit [1:0]  cv;
    bit [11:0] cp;
    int        cnt;
    bit        full;
    bit        empty;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   checks   = 0;
  int   failures = 0;

  // model: in-flight entries oldest first, next pointer to hand out, recovery cycles left
  int m_ptr[$];
  bit m_done[$];
  int m_tail = 0;
  int m_rec  = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      #1;
      if (exp_q.size() == 0) begin
        chk("exp_queue_nonempty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk("alloc_ready",  int'(alloc_ready),  int'(e.ar));
        chk("alloc_ptr",    int'(alloc_ptr),    int'(e.ap));
        chk("commit_valid", int'(commit_valid), int'(e.cv));
        chk("commit_ptr",   int'(commit_ptr),   int'(e.cp));
        chk("count",        int'(count),        e.cnt);
        chk("full",         int'(full),         int'(e.full));
        chk("empty",        int'(empty),        int'(e.empty));
      end
    end
  end

  task automatic step(input bit rst, input bit [1:0] av, input bit [3:0] cv,
                      input bit [23:0] cp, input bit fl, input bit cr_en);
    exp_t     e;
    int       sz;
    int       head;
    int       na;
    bit       ok;
    bit [1:0] ecv;
    @(negedge clk);
    sz   = m_ptr.size();
    head = (sz > 0) ? m_ptr[0] : m_tail;
    na   = $countones(av);
    e.ar = (m_rec == 0) && !fl && ((DEPTH - sz) >= na);
    e.ap = '0;
    e.cp = '0;
    for (int i = 0; i < 2; i++) begin
      e.ap[i*PW +: PW] = 6'((m_tail + i) % DEPTH);
      e.cp[i*PW +: PW] = 6'((head + i) % DEPTH);
    end
    ok  = (m_rec == 0);
    ecv = '0;
    for (int i = 0; i < 2; i++) begin
      if (i >= sz) ok = 1'b0;
      else if (!m_done[i]) ok = 1'b0;
      ecv[i] = ok;
    end
    e.cv    = ecv;
    e.cnt   = sz;
    e.full  = (sz == DEPTH);
    e.empty = (sz == 0);

    reset        = rst;
    alloc_valid  = av;
    cpl_valid    = cv;
    cpl_ptr      = cp;
    flush        = fl;
    commit_ready = cr_en && (ecv != 0);
    if (!rst) begin
      exp_q.push_back(e);
      ->sample_ev;
    end

    if (rst) begin
      m_ptr.delete(); m_done.delete(); m_tail = 0; m_rec = 0;
    end else if (fl) begin
      m_ptr.delete(); m_done.delete(); m_tail = 0; m_rec = RC;
    end else begin
      if (m_rec > 0) m_rec--;
      for (int p = 0; p < 4; p++) begin
        if (cv[p]) begin
          for (int j = 0; j < m_ptr.size(); j++) begin
            if (m_ptr[j] == int'(cp[p*PW +: PW])) m_done[j] = 1'b1;
          end
        end
      end
      if (commit_ready) begin
        repeat ($countones(ecv)) begin
          void'(m_ptr.pop_front());
          void'(m_done.pop_front());
        end
      end
      if (av != 0 && e.ar) begin
        for (int i = 0; i < na; i++) begin
          m_ptr.push_back((m_tail + i) % DEPTH);
          m_done.push_back(1'b0);
        end
        m_tail = (m_tail + na) % DEPTH;
      end
    end
  endtask

  function automatic bit [23:0] one_cpl(input int ptr);
    bit [23:0] cp;
    cp      = '0;
    cp[5:0] = 6'(ptr);
    return cp;
  endfunction

  task automatic rand_step(input bit fl, input bit rst);
    bit [1:0]  av;
    bit [3:0]  cv;
    bit [23:0] cp;
    int        r;
    r  = int'($urandom_range(0, 2));
    av = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
    cv = 4'($urandom_range(0, 15));
    cp = '0;
    for (int p = 0; p < 4; p++) begin
      if (m_ptr.size() > 0 && $urandom_range(0, 3) != 0)
        cp[p*PW +: PW] = 6'(m_ptr[$urandom_range(0, m_ptr.size() - 1)]);
      else
        cp[p*PW +: PW] = 6'($urandom_range(0, DEPTH - 1));
    end
    step(rst, av, cv, cp, fl, $urandom_range(0, 3) != 0);
  endtask

  initial begin
    // fill to full, one request beyond capacity
    step(1, 2'b00, 4'h0, '0, 0, 0);
    repeat (33) step(0, 2'b11, 4'h0, '0, 0, 0);
    step(0, 2'b00, 4'h0, '0, 0, 0);

    // out-of-order completion, then paired commit
    step(1, 2'b00, 4'h0, '0, 0, 0);
    repeat (2) step(0, 2'b11, 4'h0, '0, 0, 0);
    step(0, 2'b00, 4'h1, one_cpl(1), 0, 1);
    step(0, 2'b00, 4'h1, one_cpl(0), 0, 1);
    step(0, 2'b00, 4'h0, '0, 0, 1);
    // gap at ptr 3 stops retirement after ptr 2
    step(0, 2'b00, 4'h1, one_cpl(2), 0, 1);
    repeat (3) step(0, 2'b00, 4'h0, '0, 0, 1);

    // near-full: alloc blocked while committing, granted the next cycle
    step(1, 2'b00, 4'h0, '0, 0, 0);
    repeat (31) step(0, 2'b11, 4'h0, '0, 0, 0);
    step(0, 2'b01, 4'h0, '0, 0, 0);
    step(0, 2'b00, 4'h3, {12'd0, 6'd1, 6'd0}, 0, 0);
    step(0, 2'b11, 4'h0, '0, 0, 1);
    step(0, 2'b11, 4'h0, '0, 0, 0);
    step(0, 2'b00, 4'h0, '0, 0, 0);

    // flush with 10 in flight plus simultaneous completion and allocation
    step(1, 2'b00, 4'h0, '0, 0, 0);
    repeat (5) step(0, 2'b11, 4'h0, '0, 0, 0);
    step(0, 2'b00, 4'h3, {12'd0, 6'd2, 6'd0}, 0, 0);
    step(0, 2'b11, 4'h3, {12'd0, 6'd3, 6'd1}, 1, 1);
    repeat (4) step(0, 2'b11, 4'h0, '0, 0, 1);
    repeat (4) step(0, 2'b00, 4'h0, '0, 0, 1);

    // randomized traffic across pointer wrap, with rare flush and a reset that overrides flush
    step(1, 2'b00, 4'h0, '0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) step(1, 2'b11, 4'hF, '0, 1, 1);
      else rand_step($urandom_range(0, 59) == 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    #3;
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
